// File: rtl/gear_seq_pkg.sv
// Shared types and helpers for the gear switch sequencer: channel FSM states,
// gear code legality tables and saturating statistics arithmetic.
package gear_seq_pkg;

    localparam int unsigned GEAR_W = 8;
    localparam int unsigned QCNT_W = 8;
    localparam int unsigned TCNT_W = 16;
    localparam int unsigned STAT_W = 16;

    localparam logic [GEAR_W-1:0] GEAR_NONE = 8'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        WAIT_BND = 2'd2,
        REQ      = 2'd3
    } chan_state_e;

    function automatic logic tx_gear_legal(input logic [GEAR_W-1:0] code);
        return ((code >= 8'h80) && (code <= 8'h94)) ||
               ((code >= 8'hC0) && (code <= 8'hC7)) ||
               (code == 8'hCA);
    endfunction

    function automatic logic rx_gear_legal(input logic [GEAR_W-1:0] code);
        return ((code >= 8'h42) && (code <= 8'h4F)) ||
               (code == 8'h51) || (code == 8'h52);
    endfunction

    // Add 0..2 to a statistics counter, sticking at all-ones.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [1:0]        inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + (STAT_W+1)'(inc);
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/gear_chan_seq.sv
// One gear direction: input synchroniser, stability qualification, frame
// boundary alignment and cfg_req/cfg_ack handshake with ack timeout.
module gear_chan_seq
    import gear_seq_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter bit          IS_TX       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GEAR_W-1:0] gear_in,
    input  logic              frame_end,
    input  logic              cfg_ack,
    output logic              cfg_req,
    output logic [GEAR_W-1:0] gear_new,
    output logic [GEAR_W-1:0] gear_cur,
    output logic              done,
    output logic              err
);

    chan_state_e       state_q, state_d;
    logic [GEAR_W-1:0] sync_q1, sync_q2, cand_q;
    logic [QCNT_W-1:0] qual_cnt_q;
    logic [TCNT_W-1:0] to_cnt_q;

    logic              legal_c, ack_c, tout_c, qual_last_c;
    logic              req_d, done_d, err_d;
    logic [GEAR_W-1:0] cur_d, new_d;

    assign legal_c     = IS_TX ? tx_gear_legal(sync_q2) : rx_gear_legal(sync_q2);
    assign ack_c       = cfg_ack && cfg_req;
    assign tout_c      = (to_cnt_q == TCNT_W'(ACK_TIMEOUT - 1));
    assign qual_last_c = (qual_cnt_q == QCNT_W'(STABLE_CYC - 2));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an input change outranks a coincident frame boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (legal_c && (sync_q2 != gear_cur)) state_d = QUAL;
            QUAL:     if (sync_q2 != cand_q)  state_d = IDLE;
                      else if (qual_last_c)   state_d = WAIT_BND;
            WAIT_BND: if (sync_q2 != cand_q)  state_d = IDLE;
                      else if (frame_end)     state_d = REQ;
            REQ:      if (ack_c || tout_c)    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode; ack beats a timeout on the terminal cycle
    always_comb begin
        req_d  = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        cur_d  = gear_cur;
        new_d  = gear_new;
        if (state_d == REQ) req_d = 1'b1;
        if ((state_q == WAIT_BND) && (state_d == REQ)) new_d = cand_q;
        if ((state_q == REQ) && ack_c) begin
            done_d = 1'b1;
            cur_d  = gear_new;
        end else if ((state_q == REQ) && tout_c) begin
            err_d = 1'b1;
        end
    end

    // Synchroniser, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1    <= GEAR_NONE;
            sync_q2    <= GEAR_NONE;
            cand_q     <= GEAR_NONE;
            qual_cnt_q <= '0;
            to_cnt_q   <= '0;
            cfg_req    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            gear_cur   <= GEAR_NONE;
            gear_new   <= GEAR_NONE;
        end else begin
            sync_q1    <= gear_in;
            sync_q2    <= sync_q1;
            if (state_q == IDLE) cand_q <= sync_q2;
            qual_cnt_q <= (state_q == QUAL) ? qual_cnt_q + QCNT_W'(1) : '0;
            to_cnt_q   <= (state_q == REQ)  ? to_cnt_q + TCNT_W'(1)   : '0;
            cfg_req    <= req_d;
            done       <= done_d;
            err        <= err_d;
            gear_cur   <= cur_d;
            gear_new   <= new_d;
        end
    end

endmodule

// File: rtl/gear_switch_seq.sv
// Gear switch sequencer: independent tx/rx gear channels plus optional
// switch/error statistics (enabled with GEAR_SEQ_STATS_EN).
module gear_switch_seq
    import gear_seq_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GEAR_W-1:0] up_gear,
    input  logic [GEAR_W-1:0] down_gear,
    input  logic              tx_frame_end,
    input  logic              rx_frame_end,
    input  logic              tx_cfg_ack,
    input  logic              rx_cfg_ack,
    output logic              tx_cfg_req,
    output logic              rx_cfg_req,
    output logic [GEAR_W-1:0] tx_gear_new,
    output logic [GEAR_W-1:0] rx_gear_new,
    output logic [GEAR_W-1:0] tx_gear_cur,
    output logic [GEAR_W-1:0] rx_gear_cur,
    output logic              tx_done,
    output logic              rx_done,
    output logic              tx_err,
    output logic              rx_err,
    output logic [STAT_W-1:0] tx_sw_cnt,
    output logic [STAT_W-1:0] rx_sw_cnt,
    output logic [STAT_W-1:0] err_cnt
);

    gear_chan_seq #(
        .STABLE_CYC (STABLE_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .IS_TX      (1'b1)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .gear_in  (up_gear),
        .frame_end(tx_frame_end),
        .cfg_ack  (tx_cfg_ack),
        .cfg_req  (tx_cfg_req),
        .gear_new (tx_gear_new),
        .gear_cur (tx_gear_cur),
        .done     (tx_done),
        .err      (tx_err)
    );

    gear_chan_seq #(
        .STABLE_CYC (STABLE_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .IS_TX      (1'b0)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .gear_in  (down_gear),
        .frame_end(rx_frame_end),
        .cfg_ack  (rx_cfg_ack),
        .cfg_req  (rx_cfg_req),
        .gear_new (rx_gear_new),
        .gear_cur (rx_gear_cur),
        .done     (rx_done),
        .err      (rx_err)
    );

`ifdef GEAR_SEQ_STATS_EN
    // Saturating counters; a dual error in one cycle counts twice
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sw_cnt <= '0;
            rx_sw_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            tx_sw_cnt <= sat_add(tx_sw_cnt, {1'b0, tx_done});
            rx_sw_cnt <= sat_add(rx_sw_cnt, {1'b0, rx_done});
            err_cnt   <= sat_add(err_cnt, 2'(tx_err) + 2'(rx_err));
        end
    end
`else
    assign tx_sw_cnt = '0;
    assign rx_sw_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_gear_switch_seq.sv
// Scoreboard bench for gear_switch_seq: transaction-level model predicts
// req/done/err events; a negedge monitor pops and compares them.
module tb_gear_switch_seq;

    localparam int STABLE = 16;
    localparam int TO     = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  up_gear = 8'h00, down_gear = 8'h00;
    logic        tx_frame_end = 1'b0, rx_frame_end = 1'b0;
    logic        tx_cfg_ack = 1'b0, rx_cfg_ack = 1'b0;
    logic        tx_cfg_req, rx_cfg_req, tx_done, rx_done, tx_err, rx_err;
    logic [7:0]  tx_gear_new, rx_gear_new, tx_gear_cur, rx_gear_cur;
    logic [15:0] tx_sw_cnt, rx_sw_cnt, err_cnt;

    gear_switch_seq #(.STABLE_CYC(STABLE), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .up_gear(up_gear), .down_gear(down_gear),
        .tx_frame_end(tx_frame_end), .rx_frame_end(rx_frame_end),
        .tx_cfg_ack(tx_cfg_ack), .rx_cfg_ack(rx_cfg_ack),
        .tx_cfg_req(tx_cfg_req), .rx_cfg_req(rx_cfg_req),
        .tx_gear_new(tx_gear_new), .rx_gear_new(rx_gear_new),
        .tx_gear_cur(tx_gear_cur), .rx_gear_cur(rx_gear_cur),
        .tx_done(tx_done), .rx_done(rx_done), .tx_err(tx_err), .rx_err(rx_err),
        .tx_sw_cnt(tx_sw_cnt), .rx_sw_cnt(rx_sw_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;   // 0 req rise, 1 done, 2 err
        logic [7:0] gear;   // gear_new on req, gear_cur on done/err
        int         at;
    } ev_t;

    ev_t        q_tx[$], q_rx[$];
    logic [7:0] cur_m[2];
    int         sw_m[2];
    int         err_m;
    logic [7:0] legal_q[2][$];
    int         n_checks = 0, n_fail = 0;
    logic       prev_tx_req = 1'b0, prev_rx_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input int ch, input logic [7:0] code);
        foreach (legal_q[ch][i]) if (legal_q[ch][i] == code) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_ev(input int ch, input int kind, input logic [7:0] g, input int at);
        ev_t ev;
        ev.kind = kind; ev.gear = g; ev.at = at;
        if (ch == 0) q_tx.push_back(ev); else q_rx.push_back(ev);
    endtask

    task automatic see_ev(input int ch, input int kind, input logic [7:0] g);
        ev_t ev;
        string nm;
        nm = (ch == 0) ? "tx" : "rx";
        if ((ch == 0 && q_tx.size() == 0) || (ch == 1 && q_rx.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected_event: got kind %0d gear %0h, expected none (cycle %0d)",
                     nm, kind, g, cyc);
            return;
        end
        ev = (ch == 0) ? q_tx.pop_front() : q_rx.pop_front();
        chk({nm, "_event_kind"}, 32'(kind), 32'(ev.kind));
        chk({nm, "_event_gear"}, 32'(g), 32'(ev.gear));
        chk({nm, "_event_cycle"}, 32'(cyc), 32'(ev.at));
    endtask

    // Monitor: every req rise and done/err pulse must match the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_cfg_req && !prev_tx_req) see_ev(0, 0, tx_gear_new);
            if (tx_done) see_ev(0, 1, tx_gear_cur);
            if (tx_err)  see_ev(0, 2, tx_gear_cur);
            if (rx_cfg_req && !prev_rx_req) see_ev(1, 0, rx_gear_new);
            if (rx_done) see_ev(1, 1, rx_gear_cur);
            if (rx_err)  see_ev(1, 2, rx_gear_cur);
        end
        prev_tx_req = tx_cfg_req;
        prev_rx_req = rx_cfg_req;
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_gear(input int ch, input logic [7:0] v);
        if (ch == 0) up_gear = v; else down_gear = v;
    endtask
    task automatic set_fe(input int ch, input logic v);
        if (ch == 0) tx_frame_end = v; else rx_frame_end = v;
    endtask
    task automatic set_ack(input int ch, input logic v);
        if (ch == 0) tx_cfg_ack = v; else rx_cfg_ack = v;
    endtask

    // Drive a code, hold it, pulse frame_end after 'hold' cycles, ack after ack_d (0 = never).
    // A legal code differing from the applied gear and held long enough yields a request on
    // the frame_end edge; ack within TO cycles completes it, otherwise err at TO.
    task automatic run_txn(input int ch, input logic [7:0] code, input int hold,
                           input int ack_d, input bit early);
        int c0, e, last;
        bit exp_req, acked;
        c0 = cyc;
        set_gear(ch, code);
        e = c0 + hold;
        exp_req = is_legal(ch, code) && (code != cur_m[ch]);
        acked   = (ack_d >= 1) && (ack_d <= TO);
        last    = e + ((ack_d > 0) ? ack_d : 0) + 3;
        if (exp_req) begin
            push_ev(ch, 0, code, e);
            if (acked) begin
                push_ev(ch, 1, code, e + ack_d);
                cur_m[ch] = code;
                sw_m[ch]++;
            end else begin
                push_ev(ch, 2, cur_m[ch], e + TO);
                err_m++;
                last = e + TO + 3;
            end
        end
        wait_cyc(e - (early ? 2 : 1));
        set_fe(ch, 1'b1);
        wait_cyc(e);
        set_fe(ch, 1'b0);
        if (ack_d > 0) begin
            wait_cyc(e + ack_d - 1);
            set_ack(ch, 1'b1);
            wait_cyc(e + ack_d);
            set_ack(ch, 1'b0);
        end
        wait_cyc(last);
    endtask

    task automatic chk_stats(input string tag);
`ifdef GEAR_SEQ_STATS_EN
        chk({tag, "_tx_sw_cnt"}, 32'(tx_sw_cnt), 32'(sw_m[0]));
        chk({tag, "_rx_sw_cnt"}, 32'(rx_sw_cnt), 32'(sw_m[1]));
        chk({tag, "_err_cnt"},   32'(err_cnt),   32'(err_m));
`else
        chk({tag, "_tx_sw_cnt"}, 32'(tx_sw_cnt), 32'd0);
        chk({tag, "_rx_sw_cnt"}, 32'(rx_sw_cnt), 32'd0);
        chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, r, ack_d;
        logic [7:0] code;

        for (int v = 8'h80; v <= 8'h94; v++) legal_q[0].push_back(8'(v));
        for (int v = 8'hC0; v <= 8'hC7; v++) legal_q[0].push_back(8'(v));
        legal_q[0].push_back(8'hCA);
        for (int v = 8'h42; v <= 8'h4F; v++) legal_q[1].push_back(8'(v));
        legal_q[1].push_back(8'h51);
        legal_q[1].push_back(8'h52);
        cur_m[0] = 8'h00; cur_m[1] = 8'h00;
        sw_m[0] = 0; sw_m[1] = 0; err_m = 0;

        // Reset state
        wait_cyc(3);
        chk("rst_tx_req", 32'(tx_cfg_req), 32'd0);
        chk("rst_rx_req", 32'(rx_cfg_req), 32'd0);
        chk("rst_tx_cur", 32'(tx_gear_cur), 32'h00);
        chk("rst_rx_cur", 32'(rx_gear_cur), 32'h00);
        chk("rst_tx_new", 32'(tx_gear_new), 32'h00);
        chk("rst_pulses", 32'({tx_done, rx_done, tx_err, rx_err}), 32'd0);
        rst = 1'b0;
        wait_cyc(5);

        // Basic tx switch, then minimum-latency boundary with one-early frame_end
        run_txn(0, 8'h8E, 30, 1, 1'b0);
        chk("tx_cur_8e", 32'(tx_gear_cur), 32'h8E);
        run_txn(0, 8'h90, 2 + STABLE + 1, 2, 1'b1);

        // Toggling input never qualifies
        for (int k = 0; k < 12; k++) begin
            int t0;
            t0 = cyc;
            up_gear = (k % 2 == 0) ? 8'h8E : 8'h8F;
            wait_cyc(t0 + 5); tx_frame_end = 1'b1;
            wait_cyc(t0 + 6); tx_frame_end = 1'b0;
            wait_cyc(t0 + 8);
        end
        chk("toggle_tx_cur", 32'(tx_gear_cur), 32'h90);

        // Illegal rx code held 100 cycles, with stray frame_end and ack
        begin
            int t0;
            t0 = cyc;
            down_gear = 8'h50;
            for (int k = 1; k <= 10; k++) begin
                wait_cyc(t0 + 10 * k - 1); rx_frame_end = 1'b1; rx_cfg_ack = 1'b1;
                wait_cyc(t0 + 10 * k);     rx_frame_end = 1'b0; rx_cfg_ack = 1'b0;
            end
            chk("illegal_rx_req", 32'(rx_cfg_req), 32'd0);
            chk("illegal_rx_cur", 32'(rx_gear_cur), 32'h00);
        end

        // rx timeout, requalification, and ack on the terminal cycle
        run_txn(1, 8'h45, 22, 3, 1'b0);
        run_txn(1, 8'h44, 22, 0, 1'b0);
        chk("timeout_rx_cur", 32'(rx_gear_cur), 32'h45);
        run_txn(1, 8'h44, 25, 5, 1'b0);
        run_txn(1, 8'h4C, 22, TO, 1'b0);
        chk("terminal_rx_cur", 32'(rx_gear_cur), 32'h4C);

        // Randomised transactions
        for (int n = 0; n < 24; n++) begin
            ch = n % 2;
            r = $urandom_range(0, 9);
            if (r < 6)      code = legal_q[ch][$urandom_range(0, legal_q[ch].size() - 1)];
            else if (r < 8) code = 8'($urandom);
            else            code = cur_m[ch];
            r = $urandom_range(0, 6);
            if (r == 0)      ack_d = 0;
            else if (r == 1) ack_d = TO;
            else if (r == 2) ack_d = TO - 1;
            else             ack_d = $urandom_range(1, 5);
            run_txn(ch, code, $urandom_range(20, 28), ack_d, 1'b0);
        end
        chk_stats("mid");

        // Reset while tx_cfg_req is high
        begin
            int c0, e;
            code = (cur_m[0] == 8'h85) ? 8'h86 : 8'h85;
            c0 = cyc;
            up_gear = code;
            e = c0 + 22;
            push_ev(0, 0, code, e);
            wait_cyc(e - 1); tx_frame_end = 1'b1;
            wait_cyc(e);     tx_frame_end = 1'b0;
            wait_cyc(e + 2); rst = 1'b1;
            wait_cyc(e + 3);
            chk("rst_mid_tx_req", 32'(tx_cfg_req), 32'd0);
            chk("rst_mid_tx_cur", 32'(tx_gear_cur), 32'h00);
            chk("rst_mid_tx_done", 32'(tx_done), 32'd0);
            rst = 1'b0;
            cur_m[0] = 8'h00; cur_m[1] = 8'h00;
            sw_m[0] = 0; sw_m[1] = 0; err_m = 0;
            wait_cyc(e + 6);
        end

        // Three switches after reset
        run_txn(0, 8'h81, 24, 2, 1'b0);
        run_txn(0, 8'h82, 24, 3, 1'b0);
        run_txn(0, 8'h83, 24, 1, 1'b0);
        chk_stats("end");

        wait_cyc(cyc + 10);
        chk("tx_queue_empty", 32'(q_tx.size()), 32'd0);
        chk("rx_queue_empty", 32'(q_rx.size()), 32'd0);
        chk("final_tx_cur", 32'(tx_gear_cur), 32'(cur_m[0]));
        chk("final_rx_cur", 32'(rx_gear_cur), 32'(cur_m[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gear_switch_seq.md
GEAR_SWITCH_SEQ -- requirements
Module: gear_switch_seq

Interface
REQ-001 Parameters: STABLE_CYC, default 16, number of consecutive equal samples that qualify a new gear code (range 2..255); ACK_TIMEOUT, default 1024, number of cycles cfg_req waits for cfg_ack (range 2..65535).
REQ-002 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 up_gear  in  8  requested uplink (tx) gear code; may be driven from another clock domain.
REQ-005 down_gear  in  8  requested downlink (rx) gear code; may be driven from another clock domain.
REQ-006 tx_frame_end / rx_frame_end  in  1 each  one-cycle pulses marking a frame boundary on each link.
REQ-007 tx_cfg_ack / rx_cfg_ack  in  1 each  acknowledgements from the parameter decoder and modem.
REQ-008 tx_cfg_req / rx_cfg_req  out  1 each  requests to apply the pending gear.
REQ-009 tx_gear_new / rx_gear_new  out  8 each  pending code; valid while the matching req is high.
REQ-010 tx_gear_cur / rx_gear_cur  out  8 each  currently applied code; this feeds the parameter decoder.
REQ-011 tx_done / rx_done / tx_err / rx_err  out  1 each  one-cycle pulses for switch complete and ack timeout.
REQ-012 tx_sw_cnt / rx_sw_cnt / err_cnt  out  16 each  statistics counters; see Configuration.

Function
REQ-013 Synchronisation: each gear input shall pass through a 2-flop synchroniser before use. Each direction shall run its own independent channel FSM.
REQ-014 Code validity:
  - Legal tx codes are 0x80-0x94, 0xC0-0xC7 and 0xCA.
  - Legal rx codes are 0x42-0x49 and 0x4A-0x4F, 0x51 and 0x52.
  - Illegal codes, and codes equal to gear_cur, shall be ignored; the FSM stays in IDLE.
REQ-015 FSM states: IDLE, QUAL, WAIT_BND, REQ.
REQ-016 IDLE: on a valid synchronised code that differs from gear_cur, latch the candidate, clear the counter and enter QUAL.
REQ-017 QUAL: the counter increments each cycle the sample equals the candidate.
  - When the counter reaches STABLE_CYC-1, enter WAIT_BND.
  - Any differing sample returns the FSM to IDLE.
REQ-018 WAIT_BND:
  - A frame_end pulse enters REQ; cfg_req rises on the next cycle with gear_new equal to the candidate.
  - A change in the synchronised input returns the FSM to IDLE; the change takes priority over a simultaneous frame_end.
REQ-019 REQ: cfg_req and gear_new shall stay constant until cfg_ack or timeout. Input changes in this state shall be ignored.
REQ-020 Ack handling:
  - cfg_ack shall be sampled only while cfg_req is registered high.
  - On ack: gear_cur takes gear_new, cfg_req drops and done pulses, all on the same edge, then the FSM returns to IDLE.
REQ-021 Timeout: after ACK_TIMEOUT cycles in REQ without ack, cfg_req drops, err pulses, gear_cur is unchanged and the FSM returns to IDLE. If the input still differs, the code is requalified from IDLE.
REQ-022 Simultaneous ack and timeout terminal count: ack wins, and no err pulse is produced.
REQ-023 Latency: with a stable input and an immediate frame_end, cfg_req rises 2 + STABLE_CYC + 1 cycles after the input changes.

Reset
REQ-024 While rst is high:
  - Both FSMs are in IDLE.
  - All req, done and err outputs are 0.
  - gear_cur and gear_new are 0x00, meaning no gear, so downstream parameters are zero.
  - Synchronisers, counters and statistics are 0.
REQ-025 Reset asserted mid-operation shall drop cfg_req on the next edge. No done pulse is produced.

Configuration
REQ-026 With GEAR_SEQ_STATS_EN defined:
  - tx_sw_cnt and rx_sw_cnt increment on each done pulse.
  - err_cnt increments on each tx_err or rx_err, and by 2 if both occur in the same cycle.
  - All three counters saturate at 0xFFFF.
REQ-027 Without GEAR_SEQ_STATS_EN, the counter ports remain present and are tied to 0.

Structure
REQ-028 Package gear_seq_pkg shall hold:
  - the FSM state enum;
  - the functions tx_gear_legal() and rx_gear_legal();
  - the GEAR_NONE = 0x00 constant.
REQ-029 Sub-module gear_chan_seq shall contain one synchroniser, the FSM, the qualification counter and the timeout counter. It is instantiated twice, once per direction, with the legality function selected by a parameter.

Verification
REQ-030 up_gear 0x00 -> 0x8E held, STABLE_CYC=16, tx_frame_end at cycle 30, tx_cfg_ack one cycle after req -> tx_cfg_req rises at cycle 31, tx_gear_new=0x8E, tx_gear_cur=0x8E with a tx_done pulse.
REQ-031 down_gear=0x50 (illegal), held for 100 cycles -> rx_cfg_req stays 0 and rx_gear_cur stays 0x00.
REQ-032 up_gear toggles 0x8E/0x8F every 8 cycles -> tx_cfg_req never asserts.
REQ-033 rx_gear_cur=0x45, down_gear -> 0x44, no ack, ACK_TIMEOUT=64 -> rx_err pulses 64 cycles after req; gear_cur stays 0x45; the code is requalified and requested again.
REQ-034 rx_cfg_ack arrives on the timeout terminal cycle -> rx_done pulses, no rx_err, rx_gear_cur is updated.
REQ-035 rst pulsed while tx_cfg_req is high -> tx_cfg_req=0 and tx_gear_cur=0x00 the next cycle. With GEAR_SEQ_STATS_EN defined, after 3 switches tx_sw_cnt=3.
